// File: rtl/buffer_read_ctrl_if.sv
// Handshake/bus bundle between the raw-hits fence buffer readout controller
// and its neighbours (sequencer, fence queue writer, raw-hits RAM).
interface buffer_read_ctrl_if #(
    parameter int MXTBIN   = 5,
    parameter int RAM_ADRB = 11,
    parameter int MXBADR   = 11,
    parameter int MXBDATA  = 32
);
    // Sequencer / fence queue side
    logic [MXTBIN-1:0]   fifo_tbins;
    logic [MXTBIN-1:0]   fifo_pretrig;
    logic                rd_start;
    logic                buf_q_empty;
    logic [MXBADR-1:0]   buf_queue_adr;
    logic [MXBDATA-1:0]  buf_queue_data;

    // RAM read port and readout status
    logic                fifo_ren;
    logic [RAM_ADRB-1:0] fifo_radr;
    logic                rd_valid;
    logic [MXTBIN-1:0]   rd_tbin;
    logic [MXBDATA-1:0]  rd_event_data;
    logic                rd_busy;
    logic                rd_done;
    logic                buf_pop;
    logic [MXBADR-1:0]   buf_pop_adr;
    logic                rd_start_err;

    // Controller view
    modport slave (
        input  fifo_tbins, fifo_pretrig, rd_start, buf_q_empty, buf_queue_adr, buf_queue_data,
        output fifo_ren, fifo_radr, rd_valid, rd_tbin, rd_event_data, rd_busy, rd_done,
               buf_pop, buf_pop_adr, rd_start_err
    );

    // Requester / environment view
    modport master (
        output fifo_tbins, fifo_pretrig, rd_start, buf_q_empty, buf_queue_adr, buf_queue_data,
        input  fifo_ren, fifo_radr, rd_valid, rd_tbin, rd_event_data, rd_busy, rd_done,
               buf_pop, buf_pop_adr, rd_start_err
    );
endinterface

// File: rtl/buffer_read_ctrl.sv
// Readout controller for the raw-hits fence buffer: takes the head fence on a
// sequencer request, sweeps the programmed tbins through the RAM read port with
// latency-aligned valid/tbin tags, then releases the fence.
module buffer_read_ctrl #(
    parameter int MXTBIN          = 5,
    parameter int RAM_ADRB        = 11,
    parameter int MXBADR          = 11,
    parameter int MXBDATA         = 32,
    parameter int READ_ADR_OFFSET = 6,
    parameter int RAM_LATENCY     = 2
) (
    input  logic              clock,
    input  logic              ttc_resync,
    buffer_read_ctrl_if.slave bus
);
    localparam int DRAIN_W = (RAM_LATENCY < 2) ? 1 : $clog2(RAM_LATENCY + 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LATCH  = 3'd1,
        S_READ   = 3'd2,
        S_DRAIN  = 3'd3,
        S_POP    = 3'd4,
        S_SETTLE = 3'd5
    } state_t;

    state_t               state_q, state_d;
    logic [MXTBIN-1:0]    tbins_q;
    logic [MXTBIN-1:0]    tbin_q;
    logic [RAM_ADRB-1:0]  start_adr_q;
    logic [MXBADR-1:0]    pop_adr_q;
    logic [MXBADR-1:0]    last_pop_q;
    logic [MXBDATA-1:0]   event_data_q;
    logic [RAM_ADRB-1:0]  radr_hold_q;
    logic [DRAIN_W-1:0]   drain_q;
    logic                 err_q;
    logic [RAM_LATENCY-1:0] valid_sr_q;
    logic [MXTBIN-1:0]    tbin_sr_q [RAM_LATENCY];

    logic                 read_last;
    logic                 drain_last;
    logic [RAM_ADRB-1:0]  cur_radr;

    assign read_last  = (tbin_q == (tbins_q - MXTBIN'(1)));
    assign drain_last = (drain_q == DRAIN_W'(RAM_LATENCY - 1));
    assign cur_radr   = start_adr_q + RAM_ADRB'(tbin_q);

    // State register; resync aborts any event in flight without a pop
    always_ff @(posedge clock or posedge ttc_resync) begin
        if (ttc_resync) state_q <= S_IDLE;
        else            state_q <= state_d;
    end

    // Next-state: one event at a time, requests outside idle are dropped
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (bus.rd_start && !bus.buf_q_empty) state_d = S_LATCH;
            S_LATCH:  state_d = (bus.fifo_tbins == '0) ? S_POP : S_READ;
            S_READ:   if (read_last) state_d = S_DRAIN;
            S_DRAIN:  if (drain_last) state_d = S_POP;
            S_POP:    state_d = S_SETTLE;
            S_SETTLE: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Outputs decoded from state; address ports hold their last value when idle
    always_comb begin
        bus.fifo_ren    = (state_q == S_READ);
        bus.fifo_radr   = (state_q == S_READ) ? cur_radr : radr_hold_q;
        bus.buf_pop     = (state_q == S_POP);
        bus.rd_done     = (state_q == S_POP);
        bus.buf_pop_adr = (state_q == S_POP) ? pop_adr_q : last_pop_q;
        bus.rd_busy     = (state_q != S_IDLE);
        bus.rd_valid    = valid_sr_q[RAM_LATENCY-1];
        bus.rd_tbin     = tbin_sr_q[RAM_LATENCY-1];
        bus.rd_event_data = event_data_q;
        bus.rd_start_err  = err_q;
    end

    // Event capture, tbin/drain counters and held addresses
    always_ff @(posedge clock or posedge ttc_resync) begin
        if (ttc_resync) begin
            tbins_q      <= '0;
            tbin_q       <= '0;
            start_adr_q  <= '0;
            pop_adr_q    <= '0;
            last_pop_q   <= '0;
            event_data_q <= '0;
            radr_hold_q  <= '0;
            drain_q      <= '0;
        end else begin
            if (state_q == S_LATCH) begin
                tbins_q      <= bus.fifo_tbins;
                tbin_q       <= '0;
                pop_adr_q    <= bus.buf_queue_adr;
                event_data_q <= bus.buf_queue_data;
                // First tbin address wraps around the RAM, no saturation
                start_adr_q  <= RAM_ADRB'(bus.buf_queue_adr) - RAM_ADRB'(READ_ADR_OFFSET)
                                - RAM_ADRB'(bus.fifo_pretrig);
            end
            if (state_q == S_READ) begin
                tbin_q      <= tbin_q + MXTBIN'(1);
                radr_hold_q <= cur_radr;
                drain_q     <= '0;
            end
            if (state_q == S_DRAIN) drain_q <= drain_q + DRAIN_W'(1);
            if (state_q == S_POP)   last_pop_q <= pop_adr_q;
        end
    end

    // Sticky error: request while queue empty or while an event is in progress
    always_ff @(posedge clock or posedge ttc_resync) begin
        if (ttc_resync) err_q <= 1'b0;
        else if (bus.rd_start && (state_q != S_IDLE || bus.buf_q_empty)) err_q <= 1'b1;
    end

    // Delay read enable and tbin tag to line up with RAM data out
    always_ff @(posedge clock or posedge ttc_resync) begin
        if (ttc_resync) begin
            valid_sr_q <= '0;
            for (int i = 0; i < RAM_LATENCY; i++) tbin_sr_q[i] <= '0;
        end else begin
            valid_sr_q[0] <= bus.fifo_ren;
            tbin_sr_q[0]  <= bus.fifo_ren ? tbin_q : '0;
            for (int i = 1; i < RAM_LATENCY; i++) begin
                valid_sr_q[i] <= valid_sr_q[i-1];
                tbin_sr_q[i]  <= tbin_sr_q[i-1];
            end
        end
    end
endmodule

// File: tb/tb_buffer_read_ctrl.sv
module tb_buffer_read_ctrl;
    logic clock = 1'b0;
    logic ttc_resync = 1'b0;

    buffer_read_ctrl_if #(.MXTBIN(5), .RAM_ADRB(11), .MXBADR(11), .MXBDATA(32)) bif ();

    buffer_read_ctrl #(
        .MXTBIN(5), .RAM_ADRB(11), .MXBADR(11), .MXBDATA(32),
        .READ_ADR_OFFSET(6), .RAM_LATENCY(2)
    ) dut (
        .clock      (clock),
        .ttc_resync (ttc_resync),
        .bus        (bif.slave)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        int          val;
        logic [31:0] dat;
    } exp_t;

    exp_t q_ren[$];
    exp_t q_val[$];
    exp_t q_pop[$];

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents an output
    always @(negedge clock) begin
        exp_t e;
        if (bif.fifo_ren === 1'b1) begin
            if (q_ren.size() == 0) check("unexpected_fifo_ren", bif.fifo_ren, 0);
            else begin
                e = q_ren.pop_front();
                check("ren_cycle", cyc, e.cyc);
                check("fifo_radr", bif.fifo_radr, e.val);
            end
        end
        if (bif.rd_valid === 1'b1) begin
            if (q_val.size() == 0) check("unexpected_rd_valid", bif.rd_valid, 0);
            else begin
                e = q_val.pop_front();
                check("valid_cycle", cyc, e.cyc);
                check("rd_tbin", bif.rd_tbin, e.val);
                check("rd_event_data", bif.rd_event_data, e.dat);
            end
        end
        if (bif.buf_pop === 1'b1) begin
            if (q_pop.size() == 0) check("unexpected_buf_pop", bif.buf_pop, 0);
            else begin
                e = q_pop.pop_front();
                check("pop_cycle", cyc, e.cyc);
                check("buf_pop_adr", bif.buf_pop_adr, e.val);
                check("rd_done_with_pop", bif.rd_done, 1);
            end
        end else if (bif.rd_done === 1'b1) begin
            check("rd_done_without_pop", bif.rd_done, 0);
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_fifo_ren"}, bif.fifo_ren, 0);
        check({tag, "_fifo_radr"}, bif.fifo_radr, 0);
        check({tag, "_rd_valid"}, bif.rd_valid, 0);
        check({tag, "_rd_tbin"}, bif.rd_tbin, 0);
        check({tag, "_rd_event_data"}, bif.rd_event_data, 0);
        check({tag, "_rd_busy"}, bif.rd_busy, 0);
        check({tag, "_rd_done"}, bif.rd_done, 0);
        check({tag, "_buf_pop"}, bif.buf_pop, 0);
        check({tag, "_buf_pop_adr"}, bif.buf_pop_adr, 0);
        check({tag, "_rd_start_err"}, bif.rd_start_err, 0);
    endtask

    // One event; start_adr is the hand-computed first RAM address
    task automatic run_event(input int qadr, input int pre, input int tb, input int start_adr,
                             input logic [31:0] dat, input int dup_at, input int abort_at);
        int   s;
        bit   done;
        exp_t e;
        done = 0;
        @(posedge clock); #1;
        s = cyc;
        bif.buf_q_empty    = 1'b0;
        bif.buf_queue_adr  = 11'(qadr);
        bif.buf_queue_data = dat;
        bif.fifo_tbins     = 5'(tb);
        bif.fifo_pretrig   = 5'(pre);
        bif.rd_start       = 1'b1;
        for (int i = 0; i < tb; i++) begin
            e.cyc = s + 2 + i; e.val = (start_adr + i) % 2048; e.dat = dat;
            q_ren.push_back(e);
            e.cyc = s + 4 + i; e.val = i;
            q_val.push_back(e);
        end
        e.cyc = (tb > 0) ? (s + 4 + tb) : (s + 2); e.val = qadr; e.dat = dat;
        q_pop.push_back(e);
        for (int k = 1; k < 80; k++) begin
            @(posedge clock); #1;
            if (k == 1) begin
                bif.rd_start = 1'b0;
                check("busy_in_latch", bif.rd_busy, 1);
            end
            if (k == 2) begin
                // Only values sampled in latch may affect the event
                bif.fifo_tbins     = 5'd31;
                bif.fifo_pretrig   = 5'd0;
                bif.buf_queue_adr  = ~11'(qadr);
                bif.buf_queue_data = ~dat;
            end
            if (dup_at != 0 && k == dup_at) bif.rd_start = 1'b1;
            if (dup_at != 0 && k == dup_at + 1) begin
                bif.rd_start = 1'b0;
                check("err_after_busy_start", bif.rd_start_err, 1);
            end
            if (abort_at != 0 && k == abort_at) begin
                #1 ttc_resync = 1'b1;
                #1 check_all_zero("abort");
                q_ren.delete(); q_val.delete(); q_pop.delete();
                @(posedge clock); #1;
                ttc_resync = 1'b0;
                done = 1;
                break;
            end
            if (k > 2 && bif.rd_busy == 1'b0) begin
                done = 1;
                break;
            end
        end
        if (!done) check("event_timeout_busy", bif.rd_busy, 0);
        if (abort_at == 0) begin
            check("ren_left", q_ren.size(), 0);
            check("valid_left", q_val.size(), 0);
            check("pop_left", q_pop.size(), 0);
            check("pop_adr_hold", bif.buf_pop_adr, qadr);
        end else begin
            repeat (12) @(posedge clock);
            #1 check("abort_idle_busy", bif.rd_busy, 0);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bif.rd_start = 0; bif.buf_q_empty = 1; bif.buf_queue_adr = 0;
        bif.buf_queue_data = 0; bif.fifo_tbins = 0; bif.fifo_pretrig = 0;
        #1 ttc_resync = 1'b1;
        #1 check_all_zero("reset");
        repeat (3) @(posedge clock);
        #1 ttc_resync = 1'b0;
        repeat (2) @(posedge clock);

        // Basic 4-tbin event: 100-6-7 = 87
        run_event(100, 7, 4, 87, 32'hA5A5_0001, 0, 0);
        check("err_clean_t1", bif.rd_start_err, 0);
        // Address wrap: 5-6-7 = -8 -> 2040
        run_event(5, 7, 12, 2040, 32'h0000_0002, 0, 0);
        // No raw hits: immediate pop
        run_event(300, 3, 0, 0, 32'h0000_0003, 0, 0);
        check("err_clean_t3", bif.rd_start_err, 0);
        // Duplicate start during read: 1000-6-2 = 992
        run_event(1000, 2, 6, 992, 32'hDEAD_0005, 3, 0);
        check("err_set_t5", bif.rd_start_err, 1);
        // Resync at third read clock: 50-6-4 = 40
        run_event(50, 4, 8, 40, 32'h0000_0006, 0, 4);
        check("err_cleared_by_resync", bif.rd_start_err, 0);
        // Normal event after abort: 2047-6-0 = 2041
        run_event(2047, 0, 3, 2041, 32'h1234_5678, 0, 0);
        check("err_clean_after_abort", bif.rd_start_err, 0);

        // Start with empty queue: error, no state change
        @(posedge clock); #1;
        bif.buf_q_empty = 1'b1;
        bif.rd_start    = 1'b1;
        @(posedge clock); #1;
        bif.rd_start = 1'b0;
        check("empty_start_busy", bif.rd_busy, 0);
        check("empty_start_err", bif.rd_start_err, 1);
        repeat (3) @(posedge clock);
        #1 check("empty_start_still_idle", bif.rd_busy, 0);

        // Error stays set across a later good event: 6-6-0 = 0
        run_event(6, 0, 2, 0, 32'h0000_0007, 0, 0);
        check("err_sticky", bif.rd_start_err, 1);

        repeat (4) @(posedge clock);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
